// File: rtl/waterbear2_pkg.sv
//==============================================================================
// Module      : waterbear2_pkg
// Description : Opcode and FSM state encodings plus instruction field helpers
//               for the waterbear2 accumulator core.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package waterbear2_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDR = 4'd1,
        OP_STR = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_EQU = 4'd5,
        OP_JMP = 4'd6,
        OP_HLT = 4'd7,
        OP_AND = 4'd8,
        OP_OR  = 4'd9,
        OP_XOR = 4'd10,
        OP_JZ  = 4'd11,
        OP_JC  = 4'd12
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam int OPC_W = 4;

    function automatic int instr_w(input int opnd_w);
        return opnd_w + OPC_W + 1;
    endfunction

    function automatic int opc_lsb(input int opnd_w);
        return opnd_w + 1;
    endfunction

    function automatic int imm_pos(input int opnd_w);
        return opnd_w;
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return (op <= OP_JC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/waterbear2_if.sv
//==============================================================================
// Module      : waterbear2_if
// Description : Instruction-memory fetch bus (req/valid handshake).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface waterbear2_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

`default_nettype wire

// File: rtl/waterbear2_alu.sv
//==============================================================================
// Module      : waterbear2_alu
// Description : Combinational ALU: load, add, subtract and bitwise logic ops.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module waterbear2_alu
    import waterbear2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] val_i,
    input  logic [OPC_W-1:0]  op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // The extra MSB carries the carry-out (add) or the borrow (subtract).
    assign w_sum  = {1'b0, acc_i} + {1'b0, val_i};
    assign w_diff = {1'b0, acc_i} - {1'b0, val_i};

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_LDR: result_o = val_i;
            OP_ADD: begin
                result_o = w_sum[DATA_W-1:0];
                carry_o  = w_sum[DATA_W];
            end
            OP_SUB: begin
                result_o = w_diff[DATA_W-1:0];
                carry_o  = w_diff[DATA_W];
            end
            OP_AND: result_o = acc_i & val_i;
            OP_OR:  result_o = acc_i | val_i;
            OP_XOR: result_o = acc_i ^ val_i;
            default: begin
                result_o = acc_i;
                carry_o  = 1'b0;
            end
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/waterbear2.sv
//==============================================================================
// Module      : waterbear2
// Description : Multi-cycle accumulator softcore with external instruction
//               fetch, internal data memory, Z/C flags and resumable halt.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module waterbear2
    import waterbear2_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int OPND_W     = 11,
    parameter int DMEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    waterbear2_if.master      imem,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] acc_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              halted_o,
    output logic              illegal_o
);

    localparam int INSTR_W = instr_w(OPND_W);
    localparam int OPC_LSB = opc_lsb(OPND_W);
    localparam int IMM_POS = imm_pos(OPND_W);
    localparam int AW      = $clog2(DMEM_DEPTH);

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [DATA_W-1:0]  acc_q;
    logic               z_q;
    logic               c_q;
    logic               req_q;
    logic               halted_q;
    logic               illegal_q;
    logic [INSTR_W-1:0] cir_q;
    logic [OPC_W-1:0]   op_q;
    logic [OPND_W-1:0]  operand_q;
    logic [DATA_W-1:0]  val_q;

    logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

    logic [DATA_W-1:0]  w_imm_val;
    logic [DATA_W-1:0]  w_dmem_rd;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    pc_exec_d;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_c;
    logic               w_alu_z;
    logic               w_acc_wr;
    logic               w_stop;
    logic               w_dmem_we;
    logic               unused_opnd;

    generate
        if (DATA_W <= OPND_W) begin : g_imm_trunc
            assign w_imm_val = cir_q[DATA_W-1:0];
        end else begin : g_imm_ext
            assign w_imm_val = {{(DATA_W-OPND_W){1'b0}}, cir_q[OPND_W-1:0]};
        end

        if (PC_W <= OPND_W) begin : g_jmp_trunc
            assign w_target = operand_q[PC_W-1:0];
        end else begin : g_jmp_ext
            assign w_target = {{(PC_W-OPND_W){1'b0}}, operand_q};
        end
    endgenerate

    assign w_dmem_rd   = dmem[cir_q[AW-1:0]];
    assign unused_opnd = ^operand_q;

    waterbear2_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc_i    (acc_q),
        .val_i    (val_q),
        .op_i     (op_q),
        .result_o (w_alu_res),
        .carry_o  (w_alu_c),
        .zero_o   (w_alu_z)
    );

    assign w_acc_wr  = op_q inside {OP_LDR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    assign w_stop    = (op_q == OP_HLT) || !is_legal(op_q);
    assign w_dmem_we = (state_q == ST_EXEC) && (op_q == OP_STR);

    // pc already points past this instruction, so a skip is one more increment.
    always_comb begin
        pc_exec_d = pc_q;
        case (op_q)
            OP_EQU:  if (acc_q == val_q) pc_exec_d = pc_q + PC_W'(1);
            OP_JMP:  pc_exec_d = w_target;
            OP_JZ:   if (z_q) pc_exec_d = w_target;
            OP_JC:   if (c_q) pc_exec_d = w_target;
            default: pc_exec_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_dmem_we) begin
            dmem[operand_q[AW-1:0]] <= acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            acc_q     <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            cir_q     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            val_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        pc_q    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        cir_q   <= imem.imem_rdata;
                        pc_q    <= pc_q + PC_W'(1);
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_q      <= cir_q[INSTR_W-1:OPC_LSB];
                    operand_q <= cir_q[OPND_W-1:0];
                    val_q     <= cir_q[IMM_POS] ? w_imm_val : w_dmem_rd;
                    state_q   <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_acc_wr) begin
                        acc_q <= w_alu_res;
                        z_q   <= w_alu_z;
                        c_q   <= w_alu_c;
                    end
                    pc_q <= pc_exec_d;
                    if (w_stop) begin
                        state_q   <= ST_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= !is_legal(op_q);
                    end else begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (run_i) begin
                        state_q   <= ST_FETCH;
                        req_q     <= 1'b1;
                        halted_q  <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign acc_o          = acc_q;
    assign flag_z_o       = z_q;
    assign flag_c_o       = c_q;
    assign halted_o       = halted_q;
    assign illegal_o      = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_waterbear2.sv
//==============================================================================
// Module      : tb_waterbear2
// Description : Self-checking bench for waterbear2: program table plus
//               wait-state, wrap, resume and mid-fetch reset sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_waterbear2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       fz, fc, halted, illegal;

    logic [15:0] imem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    logic        force_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    waterbear2_if #(.PC_W(8), .INSTR_W(16)) bus ();

    waterbear2 #(
        .DATA_W     (8),
        .PC_W       (8),
        .OPND_W     (11),
        .DMEM_DEPTH (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run),
        .imem      (bus),
        .pc_o      (pc),
        .acc_o     (acc),
        .flag_z_o  (fz),
        .flag_c_o  (fc),
        .halted_o  (halted),
        .illegal_o (illegal)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.imem_valid = (bus.imem_req && (wcnt >= wait_n)) || force_valid;

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_valid) wcnt <= 0;
        else                                 wcnt <= wcnt + 1;
    end

    int         req_cycles = 0;
    int         stab_err = 0;
    logic       prev_wait = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [7:0] hs_q [$];

    always @(negedge clk) begin
        if (bus.imem_req) req_cycles <= req_cycles + 1;
        if (prev_wait && bus.imem_req && (bus.imem_addr !== prev_addr)) stab_err <= stab_err + 1;
        if (bus.imem_req && bus.imem_valid) hs_q.push_back(bus.imem_addr);
        prev_wait <= bus.imem_req && !bus.imem_valid;
        prev_addr <= bus.imem_addr;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [15:0] H = 16'h7000;

    typedef struct {
        string           name;
        logic [7:0][15:0] p;
        logic [7:0]      acc;
        logic            z;
        logic            c;
        logic [7:0]      pc;
        logic            ill;
    } vec_t;

    vec_t vq [$];

    function automatic logic [15:0] ins(input int op, input int imm, input int opnd);
        logic [31:0] a, b, c;
        a = op; b = imm; c = opnd;
        return {a[3:0], b[0], c[10:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm,
                           input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7,
                           input logic [7:0] eacc, input logic ez, input logic ec,
                           input logic [7:0] epc, input logic eill);
        vec_t v;
        v.name = nm;
        v.p[0] = w0; v.p[1] = w1; v.p[2] = w2; v.p[3] = w3;
        v.p[4] = w4; v.p[5] = w5; v.p[6] = w6; v.p[7] = w7;
        v.acc = eacc; v.z = ez; v.c = ec; v.pc = epc; v.ill = eill;
        vq.push_back(v);
    endtask

    task automatic load(input logic [7:0][15:0] p);
        for (int i = 0; i < 256; i++) imem[i] = H;
        for (int i = 0; i < 8; i++) imem[i] = p[i];
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        if (!halted) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    int n;
    int base;
    int rq0, st0;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = H;

        // Reset state
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_z", fz, 0);
        chk("rst_c", fc, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);

        add_vec("add_carry", ins(1,1,'hF0), ins(3,1,'h20), H, H, H, H, H, H, 8'h10, 0, 1, 3, 0);
        add_vec("sub_borrow", ins(1,1,3), ins(4,1,5), H, H, H, H, H, H, 8'hFE, 0, 1, 3, 0);
        add_vec("sub_zero", ins(1,1,5), ins(4,1,5), H, H, H, H, H, H, 8'h00, 1, 0, 3, 0);
        add_vec("and", ins(1,1,'h0F), ins(8,1,'h3C), H, H, H, H, H, H, 8'h0C, 0, 0, 3, 0);
        add_vec("or_clr_c", ins(1,1,'hF0), ins(3,1,'h20), ins(9,1,1), H, H, H, H, H, 8'h11, 0, 0, 4, 0);
        add_vec("xor_zero", ins(1,1,'h0F), ins(10,1,'h0F), H, H, H, H, H, H, 8'h00, 1, 0, 3, 0);
        add_vec("imm_trunc", ins(1,1,'h7FF), H, H, H, H, H, H, H, 8'hFF, 0, 0, 2, 0);
        add_vec("str_ldr", ins(1,1,'h5A), ins(2,0,3), ins(1,1,0), ins(1,0,3), H, H, H, H, 8'h5A, 0, 0, 5, 0);
        add_vec("jc_taken", ins(1,1,'hF0), ins(3,1,'h20), ins(12,1,5), H, H, H, H, H, 8'h10, 0, 1, 6, 0);
        add_vec("jz_fall", ins(1,1,1), ins(11,1,5), H, H, H, H, H, H, 8'h01, 0, 0, 3, 0);
        add_vec("jz_taken", ins(1,1,0), ins(11,1,5), H, H, H, H, H, H, 8'h00, 1, 0, 6, 0);
        add_vec("equ_skip", ins(1,1,7), ins(5,1,7), H, H, H, H, H, H, 8'h07, 0, 0, 4, 0);
        add_vec("illegal", ins(0,0,0), ins(0,0,0), ins(14,0,0), H, H, H, H, H, 8'h00, 0, 0, 3, 1);
        add_vec("counter", ins(1,1,5), ins(2,0,15), ins(1,1,0), ins(5,0,15),
                ins(6,1,6), ins(7,0,0), ins(3,1,1), ins(6,1,3), 8'h05, 0, 0, 6, 0);

        foreach (vq[k]) begin
            load(vq[k].p);
            do_reset();
            pulse_run();
            wait_halt(vq[k].name, 400, n);
            chk({vq[k].name, "_acc"}, acc, vq[k].acc);
            chk({vq[k].name, "_z"}, fz, vq[k].z);
            chk({vq[k].name, "_c"}, fc, vq[k].c);
            chk({vq[k].name, "_pc"}, pc, vq[k].pc);
            chk({vq[k].name, "_halted"}, halted, 1);
            chk({vq[k].name, "_illegal"}, illegal, vq[k].ill);
        end

        // Resume after illegal opcode: fetch restarts at 3 with illegal cleared
        load({H, H, H, H, H, ins(14,0,0), ins(0,0,0), ins(0,0,0)});
        do_reset();
        pulse_run();
        wait_halt("ill_first", 100, n);
        chk("ill_pre_flag", illegal, 1);
        pulse_run();
        chk("resume_halted", halted, 0);
        chk("resume_illegal", illegal, 0);
        chk("resume_req", bus.imem_req, 1);
        chk("resume_addr", bus.imem_addr, 3);
        wait_halt("resume", 100, n);
        chk("resume_pc", pc, 4);
        chk("resume_ill_after", illegal, 0);

        // Zero-wait latency: three instructions in 9 cycles
        load({H, H, H, H, H, H, ins(3,1,1), ins(1,1,1)});
        wait_n = 0;
        do_reset();
        pulse_run();
        wait_halt("lat0", 100, n);
        chk("lat0_cycles", n, 9);

        // Three wait states per fetch: 6 cycles per instruction, address held
        wait_n = 3;
        do_reset();
        rq0 = req_cycles;
        st0 = stab_err;
        pulse_run();
        wait_halt("lat3", 200, n);
        chk("lat3_cycles", n, 18);
        chk("lat3_acc", acc, 2);
        chk("lat3_req_cycles", req_cycles - rq0, 12);
        chk("lat3_addr_stable", stab_err - st0, 0);
        wait_n = 0;

        // JMP to 255, NOP there, next fetch wraps to 0
        for (int i = 0; i < 256; i++) imem[i] = H;
        imem[0]   = ins(6,1,255);
        imem[255] = ins(0,0,0);
        do_reset();
        base = hs_q.size();
        pulse_run();
        repeat (10) @(posedge clk);
        #1;
        chk("wrap_fetch_count", (hs_q.size() >= base + 3) ? 1 : 0, 1);
        if (hs_q.size() >= base + 3) begin
            chk("wrap_addr0", hs_q[base], 0);
            chk("wrap_addr1", hs_q[base+1], 255);
            chk("wrap_addr2", hs_q[base+2], 0);
        end

        // Reset during a fetch wait, with a late valid that must be ignored
        load({H, H, H, H, H, H, H, ins(1,1,'h33)});
        do_reset();
        pulse_run();
        wait_halt("mrst_pre", 100, n);
        chk("mrst_pre_acc", acc, 8'h33);
        wait_n = 20;
        pulse_run();
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_in_wait", bus.imem_req, 1);
        chk("mrst_wait_addr", bus.imem_addr, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_pc", pc, 0);
        chk("mrst_acc", acc, 0);
        chk("mrst_z", fz, 0);
        chk("mrst_c", fc, 0);
        chk("mrst_req", bus.imem_req, 0);
        chk("mrst_addr", bus.imem_addr, 0);
        chk("mrst_halted", halted, 0);
        chk("mrst_illegal", illegal, 0);
        force_valid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_idle_acc", acc, 0);
        chk("mrst_idle_pc", pc, 0);
        chk("mrst_idle_req", bus.imem_req, 0);
        chk("mrst_idle_halted", halted, 0);
        force_valid = 1'b0;
        wait_n = 0;
        pulse_run();
        wait_halt("mrst_post", 100, n);
        chk("mrst_post_acc", acc, 8'h33);
        chk("mrst_post_pc", pc, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
